// File: rtl/preset_recall_tx_if.sv
// Byte-wide valid/ready channel from the preset block to the UART transmitter.
interface preset_recall_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/preset_recall_tx.sv
// Four-slot MIDI program preset store: button saves capture the last received
// program number, button recalls send a two-byte Program Change.
module preset_recall_tx #(
    parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                btn_index,
    input  logic                      save_mode,
    input  logic                      rx_prog_valid,
    input  logic [6:0]                rx_prog,
    preset_recall_tx_if.master        tx,
    output logic [2:0]                active_preset,
    output logic                      save_ack,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_STATUS,
        SEND_DATA
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] slot [4];
    logic [6:0] last_prog;
    logic       have_prog;
    logic [6:0] prog_latch;

    logic       btn_hit;
    logic       do_save;
    logic       do_recall;
    logic [1:0] slot_sel;

    always_comb begin
        state_nxt   = state;
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        busy        = 1'b0;
        btn_hit     = 1'b0;
        do_save     = 1'b0;
        do_recall   = 1'b0;
        // Buttons 1..4 map onto slots 0..3; wrap of 4 -> 3 is intended.
        slot_sel    = btn_index[1:0] - 2'd1;
        case (state)
            IDLE: begin
                btn_hit   = (btn_index != 3'd0) && (btn_index <= 3'd4);
                do_save   = btn_hit && save_mode && have_prog;
                do_recall = btn_hit && !save_mode;
                if (do_recall) state_nxt = SEND_STATUS;
            end
            SEND_STATUS: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = {4'hC, MIDI_CHANNEL};
                busy        = 1'b1;
                if (tx.tx_ready) state_nxt = SEND_DATA;
            end
            SEND_DATA: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = {1'b0, prog_latch};
                busy        = 1'b1;
                if (tx.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++) slot[i] <= 7'(i);
            last_prog     <= '0;
            have_prog     <= 1'b0;
            prog_latch    <= '0;
            active_preset <= '0;
            save_ack      <= 1'b0;
        end else begin
            save_ack <= do_save;
            // Save reads last_prog before this edge's capture overwrites it.
            if (do_save) begin
                slot[slot_sel] <= last_prog;
                active_preset  <= btn_index;
            end
            if (do_recall) begin
                prog_latch    <= slot[slot_sel];
                active_preset <= btn_index;
            end
            if (rx_prog_valid) begin
                last_prog <= rx_prog;
                have_prog <= 1'b1;
            end
        end
    end

endmodule

// File: doc/preset_recall_tx.md
Name: preset_recall_tx

Overview:
- Consumes the one-cycle button events (`btn_index`, `save_mode`) from the button front end.
- Maintains 4 preset slots, each holding a 7-bit MIDI program number.
- In save mode, stores the last received MIDI program number into the selected slot.
- Otherwise, recalls the slot and transmits a 2-byte MIDI Program Change over a valid/ready byte interface to the UART transmitter.

Parameters:
- MIDI_CHANNEL, 0, 4-bit MIDI channel OR'd into the Program Change status byte (0xC0 | MIDI_CHANNEL).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- btn_index  input  3  button event; nonzero for exactly one cycle per press; 1..4 = slot, 0 = none
- save_mode  input  1  qualifies btn_index; 1 = store, 0 = recall; meaningful only when btn_index != 0
- rx_prog_valid  input  1  one-cycle strobe from MIDI receiver: a Program Change was received
- rx_prog  input  7  program number, valid with rx_prog_valid
- tx_ready  input  1  UART transmitter can accept a byte
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid
- active_preset  output  3  last saved or recalled slot (1..4); 0 = none since reset
- save_ack  output  1  one-cycle pulse when a slot is written
- busy  output  1  high while a Program Change is in flight

Behaviour:
- Reset (rst low, async): tx_valid=0, tx_data=0, active_preset=0, save_ack=0, busy=0, state=IDLE, have_prog=0, last_prog=0.
- Slot reset values: slot1=0, slot2=1, slot3=2, slot4=3.
- Program capture:
  - On rx_prog_valid: last_prog <= rx_prog and have_prog <= 1.
  - Capture is active in every state.
- Button events at cycle N:
  - Sampled only in IDLE.
  - btn_index 5..7 ignored.
  - Events arriving while busy are dropped, not queued.
- Save (btn_index in 1..4, save_mode=1, have_prog=1):
  - slot[btn_index] <= last_prog, active_preset <= btn_index, save_ack=1 in cycle N+1.
  - No transmission; state stays IDLE.
- Save with have_prog=0: ignored entirely (no write, no ack, active_preset unchanged).
- Same-cycle rx_prog_valid and save event: save stores the previous last_prog value; the new value lands in last_prog for later saves.
- Recall (btn_index in 1..4, save_mode=0): active_preset <= btn_index, prog_latch <= slot[btn_index], state -> SEND_STATUS.
- FSM:
  - IDLE: tx_valid=0, busy=0.
  - SEND_STATUS:
    - tx_valid=1, tx_data = 8'hC0 | MIDI_CHANNEL, busy=1.
    - Transfer completes on a rising clk edge where tx_valid and tx_ready are both 1; then -> SEND_DATA.
  - SEND_DATA:
    - tx_valid=1, tx_data = {1'b0, prog_latch}, busy=1.
    - On transfer -> IDLE.
- Handshake rules:
  - Once tx_valid rises, tx_data is stable and tx_valid stays high until transfer; no dependence on tx_ready to assert.
  - tx_ready may be held high continuously; then the two bytes go out on consecutive cycles.
- Timing:
  - Latency: event at edge N -> tx_valid=1 with the status byte after edge N.
  - Minimum recall occupancy is 2 cycles; busy drops after the data-byte transfer edge.
- prog_latch isolation: prog_latch is captured at recall time, so a save to the same slot during transmission cannot occur (busy drops events) and cannot corrupt the data byte.
- Reset mid-transfer: tx_valid drops immediately (async); a partial message is not resumed after reset.
- All registers update on posedge clk except the async reset.

Test Plan:
1. Reset, no rx traffic, recall slot 3 (btn_index=3, save_mode=0), tx_ready=1 -> tx_data 0xC0 then 0x02 on consecutive cycles, active_preset=3, busy high 2 cycles.
2. rx_prog_valid with rx_prog=0x2A, then save slot 2 -> save_ack pulse, active_preset=2, no tx_valid; then recall slot 2 -> bytes 0xC0, 0x2A.
3. MIDI_CHANNEL=5, recall slot 1 with tx_ready low 4 cycles -> tx_valid held, tx_data=0xC5 stable throughout; raise tx_ready -> 0xC5 then 0x00.
4. Recall slot 4, then recall slot 1 and a save pulse both during busy -> only 0xC0, 0x03 sent, active_preset=4, no save_ack.
5. Save slot 1 from reset with no prior rx -> no ack, slot1 still 0; btn_index=6 -> no response; rx_prog_valid=0x10 same cycle as save slot 3 after an earlier rx of 0x7F -> slot3=0x7F.
6. Assert rst while in SEND_DATA -> tx_valid=0 immediately, active_preset=0; after release, recall slot 2 -> 0xC0, 0x01.
